spi_burst_regfile: RTL and testbench

Parametrised successor to the single-byte SPI configuration front end. It is an SPI slave clocked directly by SCLK that receives command frames into a MEM_DEPTH-byte configuration memory, with 16-bit addressing and auto-incrementing burst reads and writes. It also holds a parametrised bank of N_FLAGS "ready" flags and a sticky range-error bit. The full memory image is exported flat to the SNN core.

---
 rtl/spi_burst_regfile.sv | 118 +++++++++++
 tb/tb_spi_burst_regfile.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/spi_burst_regfile.sv
// SPI slave register file clocked by SCLK: 16-bit addressed burst read/write
// into a MEM_DEPTH-byte memory, plus ready flags and a sticky range-error bit.
module spi_burst_regfile #(
  parameter int MEM_DEPTH = 215,
  parameter int N_FLAGS   = 3
) (
  input  logic                   SCLK,
  input  logic                   RESET,
  input  logic                   SS,
  input  logic                   MOSI,
  output logic                   MISO,
  output logic [N_FLAGS-1:0]     flags_out,
  output logic                   err_out,
  output logic [8*MEM_DEPTH-1:0] all_data_out
);

  typedef enum logic [2:0] {
    IDLE, INSTR, ADDR_H, ADDR_L, WDATA, RDATA, FLAGS, IGNORE
  } state_t;

  state_t                 r_state;
  logic [2:0]             r_bitcnt;
  logic [6:0]             r_rx;
  logic [7:0]             r_tx;
  logic [15:0]            r_addr;
  logic                   r_is_wr;
  logic [N_FLAGS-1:0]     r_flags;
  logic                   r_err;
  logic [8*MEM_DEPTH-1:0] r_mem;

  logic        w_done;
  logic [7:0]  w_byte;
  logic [15:0] w_addr_nxt;
  logic [15:0] w_ld_addr;
  logic        w_ld_ok;
  logic [7:0]  w_ld_byte;
  logic        w_wr_ok;

  assign w_done     = (r_bitcnt == 3'd7);
  assign w_byte     = {r_rx, MOSI};
  assign w_addr_nxt = r_addr + 16'd1;
  // Pre-load source: the just-completed address on entry to RDATA, else the next one.
  assign w_ld_addr  = (r_state == ADDR_L) ? {r_addr[15:8], w_byte} : w_addr_nxt;
  assign w_ld_ok    = 32'(w_ld_addr) < MEM_DEPTH;
  assign w_ld_byte  = w_ld_ok ? r_mem[32'(w_ld_addr)*8 +: 8] : 8'h00;
  assign w_wr_ok    = 32'(r_addr) < MEM_DEPTH;

  always_ff @(posedge SCLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_bitcnt <= 3'd0;
      r_rx     <= 7'd0;
      r_tx     <= 8'd0;
      r_addr   <= 16'd0;
      r_is_wr  <= 1'b0;
      r_flags  <= '0;
      r_err    <= 1'b0;
      r_mem    <= '0;
    end else if (SS) begin
      r_state  <= IDLE;
      r_bitcnt <= 3'd0;
      r_rx     <= 7'd0;
      r_tx     <= 8'd0;
    end else if (r_state == IDLE) begin
      r_state  <= INSTR;
      r_bitcnt <= 3'd1;
      r_rx     <= {6'd0, MOSI};
    end else begin
      r_bitcnt <= r_bitcnt + 3'd1;
      r_rx     <= {r_rx[5:0], MOSI};
      if (r_state == RDATA) r_tx <= {r_tx[6:0], 1'b0};
      if (w_done) begin
        case (r_state)
          INSTR: begin
            r_is_wr <= (w_byte == 8'h01);
            if (w_byte == 8'h01 || w_byte == 8'h02) r_state <= ADDR_H;
            else if (w_byte == 8'h03)               r_state <= FLAGS;
            else                                    r_state <= IGNORE;
          end
          ADDR_H: begin
            r_addr[15:8] <= w_byte;
            r_state      <= ADDR_L;
          end
          ADDR_L: begin
            r_addr[7:0] <= w_byte;
            if (r_is_wr) begin
              r_state <= WDATA;
            end else begin
              r_state <= RDATA;
              r_tx    <= w_ld_byte;
            end
          end
          WDATA: begin
            if (w_wr_ok) r_mem[32'(r_addr)*8 +: 8] <= w_byte;
            else         r_err <= 1'b1;
            r_addr <= w_addr_nxt;
          end
          RDATA: begin
            r_addr <= w_addr_nxt;
            r_tx   <= w_ld_byte;
            if (!w_ld_ok) r_err <= 1'b1;
          end
          FLAGS: begin
            r_flags <= w_byte[N_FLAGS-1:0];
            r_state <= IGNORE;
          end
          default: ;
        endcase
      end
    end
  end

  assign MISO         = r_tx[7];
  assign flags_out    = r_flags;
  assign err_out      = r_err;
  assign all_data_out = r_mem;

endmodule

// File: tb/tb_spi_burst_regfile.sv
// Directed bench for spi_burst_regfile: table of command frames with expected
// memory/flag/error/read-back values, plus abort and mid-frame reset sequences.
module tb_spi_burst_regfile;
  localparam int MEM_DEPTH = 215;
  localparam int N_FLAGS   = 3;

  logic                   SCLK = 1'b0;
  logic                   RESET, SS, MOSI;
  logic                   MISO;
  logic [N_FLAGS-1:0]     flags_out;
  logic                   err_out;
  logic [8*MEM_DEPTH-1:0] all_data_out;

  int n_chk  = 0;
  int n_fail = 0;

  spi_burst_regfile #(.MEM_DEPTH(MEM_DEPTH), .N_FLAGS(N_FLAGS)) dut (
    .SCLK(SCLK), .RESET(RESET), .SS(SS), .MOSI(MOSI), .MISO(MISO),
    .flags_out(flags_out), .err_out(err_out), .all_data_out(all_data_out)
  );

  always #5 SCLK = ~SCLK;

  typedef struct {
    int          n;
    logic [7:0]  fr [6];
    int          a0;
    logic [7:0]  v0;
    int          a1;
    logic [7:0]  v1;
    logic [2:0]  flg;
    logic        err;
    int          rd_n;
    logic [7:0]  rd [3];
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem(input int a);
    return all_data_out[8*a +: 8];
  endfunction

  // One bit per falling edge; MISO is sampled just before the bit is driven.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge SCLK);
      rx[i] = MISO;
      SS    = 1'b0;
      MOSI  = tx[i];
    end
  endtask

  task automatic end_frame();
    @(negedge SCLK);
    SS = 1'b1;
    @(negedge SCLK);
  endtask

  logic [7:0] rx;
  logic [7:0] rxs [6];
  logic [7:0] seq [5];

  initial begin
    RESET = 1'b1; SS = 1'b1; MOSI = 1'b0;
    vt[0] = '{5, '{8'h01,8'h00,8'h05,8'hAA,8'h55,8'h00}, 5, 8'hAA, 6, 8'h55, 3'b000, 1'b0, 0, '{8'h00,8'h00,8'h00}};
    vt[1] = '{6, '{8'h02,8'h00,8'h05,8'h00,8'h00,8'h00}, 5, 8'hAA, 7, 8'h00, 3'b000, 1'b0, 3, '{8'hAA,8'h55,8'h00}};
    vt[2] = '{2, '{8'h03,8'h05,8'h00,8'h00,8'h00,8'h00}, 5, 8'hAA, 6, 8'h55, 3'b101, 1'b0, 0, '{8'h00,8'h00,8'h00}};
    vt[3] = '{3, '{8'h03,8'h07,8'hFF,8'h00,8'h00,8'h00}, 5, 8'hAA, 6, 8'h55, 3'b111, 1'b0, 0, '{8'h00,8'h00,8'h00}};
    vt[4] = '{5, '{8'h01,8'h00,8'hD6,8'h11,8'h22,8'h00}, 214, 8'h11, 213, 8'h00, 3'b111, 1'b1, 0, '{8'h00,8'h00,8'h00}};
    vt[5] = '{5, '{8'h02,8'h00,8'h05,8'h00,8'h00,8'h00}, 214, 8'h11, 5, 8'hAA, 3'b111, 1'b1, 2, '{8'hAA,8'h55,8'h00}};

    repeat (2) @(negedge SCLK);
    check("reset_miso", 64'(MISO), 64'd0);
    check("reset_flags", 64'(flags_out), 64'd0);
    check("reset_err", 64'(err_out), 64'd0);
    check("reset_mem_zero", 64'(all_data_out == '0), 64'd1);
    RESET = 1'b0;
    @(negedge SCLK);

    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < vt[v].n; b++) begin
        xfer(vt[v].fr[b], 8, rx);
        rxs[b] = rx;
      end
      end_frame();
      check($sformatf("v%0d_mem%0d", v, vt[v].a0), 64'(mem(vt[v].a0)), 64'(vt[v].v0));
      check($sformatf("v%0d_mem%0d", v, vt[v].a1), 64'(mem(vt[v].a1)), 64'(vt[v].v1));
      check($sformatf("v%0d_flags", v), 64'(flags_out), 64'(vt[v].flg));
      check($sformatf("v%0d_err", v), 64'(err_out), 64'(vt[v].err));
      for (int r = 0; r < vt[v].rd_n; r++)
        check($sformatf("v%0d_rd%0d", v, r), 64'(rxs[3+r]), 64'(vt[v].rd[r]));
    end

    // Write frame aborted after 4 data bits must leave mem[5] intact.
    xfer(8'h01, 8, rx); xfer(8'h00, 8, rx); xfer(8'h05, 8, rx);
    xfer(8'h11, 4, rx);
    end_frame();
    check("abort_mem5", 64'(mem(5)), 64'hAA);
    xfer(8'h02, 8, rx); xfer(8'h00, 8, rx); xfer(8'h05, 8, rx);
    xfer(8'h00, 8, rx);
    end_frame();
    check("abort_rd5", 64'(rx), 64'hAA);

    // Asynchronous reset in the middle of a burst write.
    xfer(8'h01, 8, rx); xfer(8'h00, 8, rx); xfer(8'h10, 8, rx);
    xfer(8'h33, 8, rx); xfer(8'h44, 3, rx);
    @(negedge SCLK);
    RESET = 1'b1;
    #1;
    check("midrst_mem_zero", 64'(all_data_out == '0), 64'd1);
    check("midrst_flags", 64'(flags_out), 64'd0);
    check("midrst_err", 64'(err_out), 64'd0);
    check("midrst_miso", 64'(MISO), 64'd0);
    #1 RESET = 1'b0;
    SS = 1'b1;
    @(negedge SCLK);

    seq = '{8'h7E, 8'h01, 8'h00, 8'h00, 8'hAA};
    for (int b = 0; b < 5; b++) begin
      xfer(seq[b], 8, rx);
      check($sformatf("ign_miso_b%0d", b), 64'(rx), 64'd0);
    end
    end_frame();
    check("ign_mem_zero", 64'(all_data_out == '0), 64'd1);
    check("ign_err", 64'(err_out), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
endmodule
